rgen_response_mux_wait: RTL and testbench

- Next-generation register-block response multiplexer: collects read data and status from N registers and returns a single registered response to the host-side bus bridge.
- Unlike the fixed 1-cycle mux, it supports registers that insert wait states through a per-register ready.
- Supports per-register error reporting and a programmable timeout that converts a hung access into SLVERR.
- Sits between the register instances and the host interface adapter inside the register block.

---
 rtl/rgen_pkg.sv | 13 +
 rtl/rgen_response_selector.sv | 47 ++++
 rtl/rgen_response_mux_wait.sv | 139 +++++++++++++
 tb/tb_rgen_response_mux_wait.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgen_pkg.sv
// Shared status codes and response FSM encoding for the register-block response path.
package rgen_pkg;

    localparam logic [1:0] RGEN_STATUS_OKAY   = 2'b00;
    localparam logic [1:0] RGEN_STATUS_SLVERR = 2'b01;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } rgen_response_state_e;

endpackage

// File: rtl/rgen_response_selector.sv
// Combinational reduction of the per-register select/ready/error/data arrays into a
// single hit, ready, error and data view. Multiple selects are OR-combined.
module rgen_response_selector
    import rgen_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int TOTAL_REGISTERS = 1
) (
    input  logic [TOTAL_REGISTERS-1:0] i_register_select,
    input  logic [TOTAL_REGISTERS-1:0] i_register_ready,
    input  logic [TOTAL_REGISTERS-1:0] i_register_error,
    input  logic [DATA_WIDTH-1:0]      i_register_read_data [TOTAL_REGISTERS],
    output logic                       o_hit,
    output logic                       o_sel_ready,
    output logic                       o_sel_error,
    output logic [DATA_WIDTH-1:0]      o_sel_data
);

    generate
        if (TOTAL_REGISTERS == 1) begin : g_single
            assign o_hit       = i_register_select[0];
            assign o_sel_ready = i_register_select[0] & i_register_ready[0];
            assign o_sel_error = i_register_select[0] & i_register_ready[0] & i_register_error[0];
            assign o_sel_data  = i_register_select[0] ? i_register_read_data[0] : '0;
        end else begin : g_multi
            logic [TOTAL_REGISTERS-1:0] w_sel_ready_vec;
            logic [TOTAL_REGISTERS-1:0] w_sel_error_vec;

            assign w_sel_ready_vec = i_register_select & i_register_ready;
            assign w_sel_error_vec = w_sel_ready_vec & i_register_error;
            assign o_hit           = |i_register_select;
            assign o_sel_ready     = |w_sel_ready_vec;
            assign o_sel_error     = |w_sel_error_vec;

            // OR together the read data of every selected register
            always_comb begin
                o_sel_data = '0;
                for (int j = 0; j < TOTAL_REGISTERS; j++) begin
                    if (i_register_select[j]) begin
                        o_sel_data = o_sel_data | i_register_read_data[j];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/rgen_response_mux_wait.sv
// Register-block response multiplexer with wait-state support and optional timeout.
// Handshake: the host holds i_command_valid (and its select) stable from the cycle it
// is raised until the cycle o_response_ready pulses; a response is exactly one cycle
// of o_response_ready, and the host may issue a new command on the following cycle.
module rgen_response_mux_wait
    import rgen_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int TOTAL_REGISTERS = 1,
    parameter int TIMEOUT_CYCLES  = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_command_valid,
    output logic                       o_response_ready,
    output logic [DATA_WIDTH-1:0]      o_read_data,
    output logic [1:0]                 o_status,
    output logic                       o_timeout,
    input  logic [TOTAL_REGISTERS-1:0] i_register_select,
    input  logic [TOTAL_REGISTERS-1:0] i_register_ready,
    input  logic [TOTAL_REGISTERS-1:0] i_register_error,
    input  logic [DATA_WIDTH-1:0]      i_register_read_data [TOTAL_REGISTERS]
);

    // Wait counter is wide enough to hold TIMEOUT_CYCLES; kept at one bit when disabled.
    localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam int              CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    rgen_response_state_e  r_state;
    rgen_response_state_e  w_state_next;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      w_count_next;
    logic                  r_response_ready;
    logic                  w_response_ready_next;
    logic [1:0]            r_status;
    logic [1:0]            w_status_next;
    logic [DATA_WIDTH-1:0] r_read_data;
    logic [DATA_WIDTH-1:0] w_read_data_next;
    logic                  r_timeout;
    logic                  w_timeout_next;

    logic                  w_hit;
    logic                  w_sel_ready;
    logic                  w_sel_error;
    logic [DATA_WIDTH-1:0] w_sel_data;

    rgen_response_selector #(
        .DATA_WIDTH      (DATA_WIDTH),
        .TOTAL_REGISTERS (TOTAL_REGISTERS)
    ) u_selector (
        .i_register_select    (i_register_select),
        .i_register_ready     (i_register_ready),
        .i_register_error     (i_register_error),
        .i_register_read_data (i_register_read_data),
        .o_hit                (w_hit),
        .o_sel_ready          (w_sel_ready),
        .o_sel_error          (w_sel_error),
        .o_sel_data           (w_sel_data)
    );

    // Next state, wait counter and the response values loaded into the output flops
    always_comb begin
        w_state_next          = r_state;
        w_count_next          = r_count;
        w_response_ready_next = 1'b0;
        w_status_next         = RGEN_STATUS_OKAY;
        w_read_data_next      = '0;
        w_timeout_next        = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_command_valid) begin
                    if (!w_hit) begin
                        // decode error: nothing selected
                        w_state_next          = RESPOND;
                        w_response_ready_next = 1'b1;
                        w_status_next         = RGEN_STATUS_SLVERR;
                    end else if (w_sel_ready) begin
                        w_state_next          = RESPOND;
                        w_response_ready_next = 1'b1;
                        w_status_next         = {1'b0, w_sel_error};
                        w_read_data_next      = w_sel_error ? '0 : w_sel_data;
                    end else begin
                        w_state_next = WAIT;
                        w_count_next = '0;
                    end
                end
            end
            WAIT: begin
                if (w_sel_ready) begin
                    // ready wins over a timeout landing in the same cycle
                    w_state_next          = RESPOND;
                    w_response_ready_next = 1'b1;
                    w_status_next         = {1'b0, w_sel_error};
                    w_read_data_next      = w_sel_error ? '0 : w_sel_data;
                end else if (TIMEOUT_EN && (r_count == CNT_LAST)) begin
                    w_state_next          = RESPOND;
                    w_response_ready_next = 1'b1;
                    w_status_next         = RGEN_STATUS_SLVERR;
                    w_timeout_next        = 1'b1;
                end else if (TIMEOUT_EN && (r_count != CNT_MAX)) begin
                    w_count_next = r_count + CNT_W'(1);
                end
            end
            RESPOND: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State, counter and registered response outputs; reset abandons any access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_count          <= '0;
            r_response_ready <= 1'b0;
            r_status         <= RGEN_STATUS_OKAY;
            r_read_data      <= '0;
            r_timeout        <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_count          <= w_count_next;
            r_response_ready <= w_response_ready_next;
            r_status         <= w_status_next;
            r_read_data      <= w_read_data_next;
            r_timeout        <= w_timeout_next;
        end
    end

    assign o_response_ready = r_response_ready;
    assign o_status         = r_status;
    assign o_read_data      = r_read_data;
    assign o_timeout        = r_timeout;

endmodule

// File: tb/tb_rgen_response_mux_wait.sv
// Bench for rgen_response_mux_wait: a 4-register instance with a 5-cycle timeout and a
// 1-register instance with no timeout, driven by random commands and checked by a
// scoreboard against an expectation computed from the command's ready delay.
module tb_rgen_response_mux_wait;

    localparam int DW   = 32;
    localparam int NA   = 4;
    localparam int TA   = 5;
    localparam int NB   = 1;
    localparam int TB_T = 0;

    typedef struct {
        logic [1:0]    status;
        logic [DW-1:0] data;
        logic          timeout;
        int            cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    exp_t exp_a[$];
    exp_t exp_b[$];

    logic          a_valid;
    logic [NA-1:0] a_sel;
    logic [NA-1:0] a_rdy;
    logic [NA-1:0] a_err;
    logic [DW-1:0] a_data [NA];
    logic          a_resp;
    logic [DW-1:0] a_rdata;
    logic [1:0]    a_status;
    logic          a_to;

    logic          b_valid;
    logic [NB-1:0] b_sel;
    logic [NB-1:0] b_rdy;
    logic [NB-1:0] b_err;
    logic [DW-1:0] b_data [NB];
    logic          b_resp;
    logic [DW-1:0] b_rdata;
    logic [1:0]    b_status;
    logic          b_to;

    rgen_response_mux_wait #(.DATA_WIDTH(DW), .TOTAL_REGISTERS(NA), .TIMEOUT_CYCLES(TA)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_command_valid(a_valid),
        .o_response_ready(a_resp), .o_read_data(a_rdata), .o_status(a_status), .o_timeout(a_to),
        .i_register_select(a_sel), .i_register_ready(a_rdy), .i_register_error(a_err),
        .i_register_read_data(a_data)
    );

    rgen_response_mux_wait #(.DATA_WIDTH(DW), .TOTAL_REGISTERS(NB), .TIMEOUT_CYCLES(TB_T)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_command_valid(b_valid),
        .o_response_ready(b_resp), .o_read_data(b_rdata), .o_status(b_status), .o_timeout(b_to),
        .i_register_select(b_sel), .i_register_ready(b_rdy), .i_register_error(b_err),
        .i_register_read_data(b_data)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected response for one command: the selected registers become ready dly
    // cycles after the accept cycle; a wait longer than the timeout becomes SLVERR.
    function automatic exp_t model(input logic [NA-1:0] sel, input int dly,
                                   input logic [NA-1:0] errs, input logic [DW-1:0] d[NA],
                                   input int to_cycles, input int t0);
        exp_t          e;
        logic [DW-1:0] ord;
        logic          oerr;
        int            lat;
        ord  = '0;
        oerr = 1'b0;
        for (int i = 0; i < NA; i++) begin
            if (sel[i]) begin
                ord  = ord | d[i];
                oerr = oerr | errs[i];
            end
        end
        if (sel == '0) begin
            lat = 1; e.status = 2'b01; e.data = '0; e.timeout = 1'b0;
        end else if (to_cycles > 0 && dly > to_cycles) begin
            lat = 1 + to_cycles; e.status = 2'b01; e.data = '0; e.timeout = 1'b1;
        end else begin
            lat = 1 + dly; e.status = {1'b0, oerr}; e.data = oerr ? '0 : ord; e.timeout = 1'b0;
        end
        e.cyc = t0 + lat;
        return e;
    endfunction

    // ---------------- driver ----------------
    task automatic idle_inputs();
        a_valid = 1'b0; a_sel = '0; a_rdy = NA'($urandom); a_err = NA'($urandom);
        for (int i = 0; i < NA; i++) a_data[i] = $urandom;
        b_valid = 1'b0; b_sel = '0; b_rdy = NB'($urandom); b_err = NB'($urandom);
        b_data[0] = $urandom;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one command on instance A (on_b=0) or B (on_b=1); called at posedge+1.
    task automatic cmd(input bit on_b, input logic [NA-1:0] sel_in, input int dly,
                       input logic [NA-1:0] errs, input logic [DW-1:0] d[NA]);
        exp_t          e;
        logic [NA-1:0] sel;
        logic [NA-1:0] rdy;
        int            lat;
        sel = on_b ? (sel_in & NA'(1)) : sel_in;
        e   = model(sel, dly, errs, d, on_b ? TB_T : TA, cyc);
        lat = e.cyc - cyc;
        if (on_b) exp_b.push_back(e);
        else      exp_a.push_back(e);
        for (int k = 0; k <= lat; k++) begin
            rdy = (NA'($urandom) & ~sel) | ((k >= dly) ? sel : '0);
            if (on_b) begin
                b_valid = 1'b1; b_sel = sel[0]; b_rdy = rdy[0]; b_err = errs[0]; b_data[0] = d[0];
            end else begin
                a_valid = 1'b1; a_sel = sel; a_rdy = rdy; a_err = errs; a_data = d;
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic rand_cmd(input bit on_b, input logic [NA-1:0] sel, input int dly);
        logic [DW-1:0] d[NA];
        logic [NA-1:0] errs;
        for (int i = 0; i < NA; i++) d[i] = $urandom;
        errs = NA'($urandom & $urandom);
        cmd(on_b, sel, dly, errs, d);
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic mon(input bit on_b, input logic resp, input logic [1:0] st,
                       input logic [DW-1:0] rd, input logic to);
        exp_t  e;
        string p;
        p = on_b ? "b" : "a";
        if (resp) begin
            if ((on_b && exp_b.size() == 0) || (!on_b && exp_a.size() == 0)) begin
                tests++;
                fails++;
                $display("FAIL %s_spurious_ready: actual=1 required=0 (cycle %0d)", p, cyc);
            end else begin
                if (on_b) e = exp_b.pop_front();
                else      e = exp_a.pop_front();
                chk({p, "_resp_cycle"}, DW'(cyc), DW'(e.cyc));
                chk({p, "_status"},     DW'(st),  DW'(e.status));
                chk({p, "_data"},       rd,       e.data);
                chk({p, "_timeout"},    DW'(to),  DW'(e.timeout));
            end
        end else begin
            chk({p, "_idle_status"},  DW'(st), '0);
            chk({p, "_idle_data"},    rd,      '0);
            chk({p, "_idle_timeout"}, DW'(to), '0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(1'b0, a_resp, a_status, a_rdata, a_to);
            mon(1'b1, b_resp, b_status, b_rdata, b_to);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] d[NA];
        logic [NA-1:0] sel;
        int            r;

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) next_cycle();
        chk("a_reset_ready",  DW'(a_resp),   '0);
        chk("a_reset_status", DW'(a_status), '0);
        chk("a_reset_data",   a_rdata,       '0);
        chk("a_reset_to",     DW'(a_to),     '0);
        chk("b_reset_ready",  DW'(b_resp),   '0);
        chk("b_reset_data",   b_rdata,       '0);
        rst_n = 1'b1;
        repeat (2) next_cycle();

        // reg2 ready at once, 0xDEADBEEF
        for (int i = 0; i < NA; i++) d[i] = $urandom;
        d[2] = 32'hDEADBEEF;
        cmd(1'b0, 4'b0100, 0, 4'b1011, d);
        next_cycle();
        // decode error
        rand_cmd(1'b0, 4'b0000, 0);
        next_cycle();
        // reg1 ready after 3 cycles with error
        for (int i = 0; i < NA; i++) d[i] = $urandom;
        d[1] = 32'h1234;
        cmd(1'b0, 4'b0010, 3, 4'b0010, d);
        next_cycle();
        // reg0 never ready -> timeout; then ready exactly at the timeout cycle
        rand_cmd(1'b0, 4'b0001, 1000);
        rand_cmd(1'b0, 4'b0001, TA);
        rand_cmd(1'b0, 4'b0001, TA + 1);

        // reset during WAIT: no response, outputs stay zero
        a_valid = 1'b1; a_sel = 4'b0001; a_rdy = 4'b0000; a_err = '0;
        repeat (3) next_cycle();
        rst_n = 1'b0;
        #1;
        chk("rst_wait_ready", DW'(a_resp), '0);
        chk("rst_wait_status", DW'(a_status), '0);
        next_cycle();
        idle_inputs();
        rst_n = 1'b1;
        repeat (3) next_cycle();

        // reset while the response is showing: outputs clear immediately
        a_valid = 1'b1; a_sel = 4'b1000; a_rdy = 4'b1000; a_err = 4'b0000;
        a_data[3] = 32'hA5A5_0F0F;
        next_cycle();
        chk("pre_rst_ready", DW'(a_resp), 1);
        chk("pre_rst_data", a_rdata, 32'hA5A5_0F0F);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_resp_ready",  DW'(a_resp),   '0);
        chk("rst_resp_data",   a_rdata,       '0);
        chk("rst_resp_status", DW'(a_status), '0);
        next_cycle();
        idle_inputs();
        rst_n = 1'b1;
        repeat (2) next_cycle();

        // fresh command after reset completes in one cycle
        for (int i = 0; i < NA; i++) d[i] = $urandom;
        d[2] = 32'hDEADBEEF;
        cmd(1'b0, 4'b0100, 0, 4'b0000, d);
        next_cycle();

        // random commands on A: mostly one-hot, some decode errors, some double selects
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      sel = '0;
            else if (r == 1) sel = (NA'(1) << $urandom_range(0, NA - 1)) | (NA'(1) << $urandom_range(0, NA - 1));
            else             sel = NA'(1) << $urandom_range(0, NA - 1);
            rand_cmd(1'b0, sel, $urandom_range(0, TA + 2));
            repeat ($urandom_range(0, 2)) next_cycle();
        end

        // B: long 100-cycle wait with no timeout, then back-to-back commands
        rand_cmd(1'b1, 4'b0001, 100);
        for (int n = 0; n < 20; n++) rand_cmd(1'b1, 4'b0001, 0);
        rand_cmd(1'b1, 4'b0000, 0);
        for (int n = 0; n < 30; n++) begin
            rand_cmd(1'b1, NA'($urandom_range(0, 7) != 0), $urandom_range(0, 12));
            repeat ($urandom_range(0, 1)) next_cycle();
        end

        repeat (5) next_cycle();
        chk("a_missing_responses", DW'(exp_a.size()), '0);
        chk("b_missing_responses", DW'(exp_b.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #2000000;
        $display("FAIL global_timeout: actual=%0d required=finished", cyc);
        $fatal(1, "bench did not finish");
    end

endmodule
